// File: rtl/cmsdk_sram_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: port encodings,
// arbitration mode selectors and the hold counter width.
package cmsdk_sram_arbiter_pkg;

  localparam logic PORT0      = 1'b0;
  localparam logic PORT1      = 1'b1;
  localparam int   PRIO_RR    = 0;
  localparam int   PRIO_FIXED = 1;
  localparam int   HOLD_CNT_W = 4;

endpackage

// File: rtl/cmsdk_sram_arbiter_pick.sv
// Combinational grant selection for the two-port SRAM arbiter.
module cmsdk_sram_arbiter_pick
  import cmsdk_sram_arbiter_pkg::*;
#(
  parameter int MAX_HOLD  = 4,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic                  last_owner,
  input  logic [HOLD_CNT_W-1:0] hold_cnt,
  output logic                  grant0,
  output logic                  grant1
);

  localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

  logic keep_owner;
  logic winner;

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    // A zero hold count means nobody currently owns a burst (reset or idle),
    // so a tie goes to the port that did not own the bus last.
    keep_owner = (hold_cnt != '0) && (hold_cnt < MAX_HOLD_C);
    winner     = keep_owner ? last_owner : ~last_owner;
    if (PRIO_MODE == PRIO_FIXED) begin
      grant0 = valid0;
      grant1 = valid1 & ~valid0;
    end else if (valid0 && valid1) begin
      grant0 = (winner == PORT0);
      grant1 = (winner == PORT1);
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end

endmodule

// File: rtl/cmsdk_sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM with one-cycle read latency.
module cmsdk_sram_arbiter
  import cmsdk_sram_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int MAX_HOLD  = 4,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [31:0]   req0_wdata,
  input  logic [3:0]    req0_wstrb,
  output logic          rsp0_valid,
  output logic [31:0]   rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [31:0]   req1_wdata,
  input  logic [3:0]    req1_wstrb,
  output logic          rsp1_valid,
  output logic [31:0]   rsp1_rdata,
  output logic          SRAM_CS,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  input  logic [31:0]   SRAM_RDATA
);

  localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

  logic                  last_owner_q, last_owner_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_owner_q, rsp_owner_d;
  logic                  grant0, grant1, any_grant, grant_port, grant_write;
  logic [3:0]            grant_wstrb;

  // Requests are masked while in reset so the SRAM is released immediately.
  cmsdk_sram_arbiter_pick #(
    .MAX_HOLD  (MAX_HOLD),
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .valid0     (req0_valid & RESETn),
    .valid1     (req1_valid & RESETn),
    .last_owner (last_owner_q),
    .hold_cnt   (hold_cnt_q),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  always_comb begin
    any_grant   = grant0 | grant1;
    grant_port  = grant1 ? PORT1 : PORT0;
    req0_ready  = grant0;
    req1_ready  = grant1;
    SRAM_ADDR   = '0;
    SRAM_WDATA  = '0;
    grant_write = 1'b0;
    grant_wstrb = 4'h0;
    if (grant0) begin
      SRAM_ADDR   = req0_addr;
      SRAM_WDATA  = req0_wdata;
      grant_write = req0_write;
      grant_wstrb = req0_wstrb;
    end else if (grant1) begin
      SRAM_ADDR   = req1_addr;
      SRAM_WDATA  = req1_wdata;
      grant_write = req1_write;
      grant_wstrb = req1_wstrb;
    end
    SRAM_CS   = any_grant;
    SRAM_WREN = grant_write ? grant_wstrb : 4'h0;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    rsp_valid_d  = any_grant & ~grant_write;
    rsp_owner_d  = grant_port;
    if (PRIO_MODE == PRIO_FIXED) begin
      hold_cnt_d = '0;
      if (any_grant) last_owner_d = grant_port;
    end else if (!any_grant) begin
      hold_cnt_d = '0;
    end else if (grant_port == last_owner_q) begin
      if (hold_cnt_q < MAX_HOLD_C) hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      hold_cnt_d   = HOLD_CNT_W'(1);
      last_owner_d = grant_port;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last_owner_q <= PORT1;
      hold_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= PORT0;
    end else begin
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

  always_comb begin
    rsp0_valid = rsp_valid_q & (rsp_owner_q == PORT0);
    rsp1_valid = rsp_valid_q & (rsp_owner_q == PORT1);
    rsp0_rdata = rsp0_valid ? SRAM_RDATA : 32'h0;
    rsp1_rdata = rsp1_valid ? SRAM_RDATA : 32'h0;
  end

endmodule

// File: tb/tb_cmsdk_sram_arbiter.sv
// Directed bench for cmsdk_sram_arbiter: vector table plus reset, contention,
// fixed-priority and strict-alternation sequences.
module tb_cmsdk_sram_arbiter;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  typedef struct {
    req_t        r0;
    req_t        r1;
    logic [1:0]  rdy;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } vec_t;

  localparam req_t NONE = '0;
  localparam int   NV   = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [15:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic [3:0]  req0_wstrb = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [15:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic [3:0]  req1_wstrb = '0;

  logic        rr_ready0, rr_ready1, rr_rv0, rr_rv1, rr_cs;
  logic [31:0] rr_rd0, rr_rd1, rr_wdata;
  logic [15:0] rr_addr;
  logic [3:0]  rr_wren;
  logic [31:0] sram_rdata = '0;

  logic        fp_ready0, fp_ready1, fp_rv0, fp_rv1, fp_cs;
  logic [31:0] fp_rd0, fp_rd1, fp_wdata;
  logic [15:0] fp_addr;
  logic [3:0]  fp_wren;

  logic        h1_ready0, h1_ready1, h1_rv0, h1_rv1, h1_cs;
  logic [31:0] h1_rd0, h1_rd1, h1_wdata;
  logic [15:0] h1_addr;
  logic [3:0]  h1_wren;

  logic [31:0] mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        vecs [NV];

  always #5 clk = ~clk;

  cmsdk_sram_arbiter #(.AW(16), .MAX_HOLD(4), .PRIO_MODE(0)) dut_rr (
    .CLK(clk), .RESETn(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_ready0), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .rsp0_valid(rr_rv0), .rsp0_rdata(rr_rd0),
    .req1_valid(req1_valid), .req1_ready(rr_ready1), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp1_valid(rr_rv1), .rsp1_rdata(rr_rd1),
    .SRAM_CS(rr_cs), .SRAM_ADDR(rr_addr), .SRAM_WDATA(rr_wdata),
    .SRAM_WREN(rr_wren), .SRAM_RDATA(sram_rdata));

  cmsdk_sram_arbiter #(.AW(16), .MAX_HOLD(4), .PRIO_MODE(1)) dut_fp (
    .CLK(clk), .RESETn(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_ready0), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .rsp0_valid(fp_rv0), .rsp0_rdata(fp_rd0),
    .req1_valid(req1_valid), .req1_ready(fp_ready1), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp1_valid(fp_rv1), .rsp1_rdata(fp_rd1),
    .SRAM_CS(fp_cs), .SRAM_ADDR(fp_addr), .SRAM_WDATA(fp_wdata),
    .SRAM_WREN(fp_wren), .SRAM_RDATA(32'h0));

  cmsdk_sram_arbiter #(.AW(16), .MAX_HOLD(1), .PRIO_MODE(0)) dut_h1 (
    .CLK(clk), .RESETn(rst_n),
    .req0_valid(req0_valid), .req0_ready(h1_ready0), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .rsp0_valid(h1_rv0), .rsp0_rdata(h1_rd0),
    .req1_valid(req1_valid), .req1_ready(h1_ready1), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp1_valid(h1_rv1), .rsp1_rdata(h1_rd1),
    .SRAM_CS(h1_cs), .SRAM_ADDR(h1_addr), .SRAM_WDATA(h1_wdata),
    .SRAM_WREN(h1_wren), .SRAM_RDATA(32'h0));

  // Single-port SRAM: read data registered, returns pre-write contents.
  always @(posedge clk) begin
    if (rr_cs) begin
      sram_rdata <= mem[rr_addr];
      for (int b = 0; b < 4; b++)
        if (rr_wren[b]) mem[rr_addr][b*8 +: 8] <= rr_wdata[b*8 +: 8];
    end
  end

  function automatic req_t rd(input logic [15:0] a);
    rd = '{v: 1'b1, w: 1'b0, a: a, d: 32'h0, s: 4'h0};
  endfunction

  function automatic req_t wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    wr = '{v: 1'b1, w: 1'b1, a: a, d: d, s: s};
  endfunction

  task automatic drive(input req_t r0, input req_t r1);
    req0_valid = r0.v; req0_write = r0.w; req0_addr = r0.a; req0_wdata = r0.d; req0_wstrb = r0.s;
    req1_valid = r1.v; req1_write = r1.w; req1_addr = r1.a; req1_wdata = r1.d; req1_wstrb = r1.s;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   prev_g;
    int   exp_g;
    req_t rd_strb;

    rd_strb = '{v: 1'b1, w: 1'b0, a: 16'hFFFF, d: 32'h0, s: 4'hF};

    vecs[0]  = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{wr(16'h0010, 32'hDEADBEEF, 4'hF), NONE, 2'b01, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{rd(16'h0010), NONE, 2'b01, 16'h0010, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3]  = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{wr(16'h0030, 32'h11223344, 4'hF), NONE, 2'b01, 16'h0030, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{wr(16'h0030, 32'hAABBCCDD, 4'b0101), NONE, 2'b01, 16'h0030, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[6]  = '{NONE, rd(16'h0030), 2'b10, 16'h0030, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    // Byte lanes 0 and 2 took the new data, lanes 1 and 3 kept the old.
    vecs[7]  = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h11BB33DD};
    vecs[8]  = '{NONE, wr(16'h0020, 32'hCAFEF00D, 4'hF), 2'b10, 16'h0020, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[9]  = '{rd(16'h0020), NONE, 2'b01, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[10] = '{NONE, wr(16'h0020, 32'h5A5A5A5A, 4'hF), 2'b10, 16'h0020, 32'h5A5A5A5A, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{rd(16'h0020), NONE, 2'b01, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[12] = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0};
    vecs[13] = '{NONE, wr(16'hFFFF, 32'h12345678, 4'hF), 2'b10, 16'hFFFF, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{rd_strb, NONE, 2'b01, 16'hFFFF, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[15] = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0, 32'h0};
    // Tie after an idle cycle with port 0 as last owner: port 1 wins.
    vecs[16] = '{rd(16'h0010), rd(16'h0030), 2'b10, 16'h0030, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[17] = '{NONE, NONE, 2'b00, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h11BB33DD};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp0_valid", 32'(rr_rv0), 32'h0);
    chk("reset_rsp1_valid", 32'(rr_rv1), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      chk($sformatf("row%0d_ready0", i), 32'(rr_ready0), 32'(vecs[i].rdy[0]));
      chk($sformatf("row%0d_ready1", i), 32'(rr_ready1), 32'(vecs[i].rdy[1]));
      chk($sformatf("row%0d_cs", i),     32'(rr_cs),     32'(|vecs[i].rdy));
      chk($sformatf("row%0d_addr", i),   32'(rr_addr),   32'(vecs[i].addr));
      chk($sformatf("row%0d_wdata", i),  rr_wdata,       vecs[i].wdata);
      chk($sformatf("row%0d_wren", i),   32'(rr_wren),   32'(vecs[i].wren));
      chk($sformatf("row%0d_rsp0_valid", i), 32'(rr_rv0), 32'(vecs[i].rv0));
      chk($sformatf("row%0d_rsp0_rdata", i), rr_rd0,      vecs[i].rd0);
      chk($sformatf("row%0d_rsp1_valid", i), 32'(rr_rv1), 32'(vecs[i].rv1));
      chk($sformatf("row%0d_rsp1_rdata", i), rr_rd1,      vecs[i].rd1);
    end

    // Reset asserted with a read response pending and a request still valid.
    @(posedge clk);
    #1;
    drive(rd(16'h0010), NONE);
    @(posedge clk);
    #1;
    chk("rst_pre_rsp0_valid", 32'(rr_rv0), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rsp0_valid", 32'(rr_rv0), 32'h0);
    chk("rst_async_rsp1_valid", 32'(rr_rv1), 32'h0);
    chk("rst_async_rsp0_rdata", rr_rd0, 32'h0);
    chk("rst_async_cs",         32'(rr_cs), 32'h0);
    drive(NONE, NONE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after_%0d_rsp0_valid", k), 32'(rr_rv0), 32'h0);
    end

    // Continuous contention from a fresh reset state.
    @(posedge clk);
    #1;
    drive(rd(16'h0010), rd(16'h0030));
    prev_g = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_g = (i / 4) % 2;
      chk($sformatf("cont%0d_ready0", i), 32'(rr_ready0), 32'(exp_g == 0));
      chk($sformatf("cont%0d_ready1", i), 32'(rr_ready1), 32'(exp_g == 1));
      if (prev_g >= 0) begin
        chk($sformatf("cont%0d_rsp0_valid", i), 32'(rr_rv0), 32'(prev_g == 0));
        chk($sformatf("cont%0d_rsp1_valid", i), 32'(rr_rv1), 32'(prev_g == 1));
        chk($sformatf("cont%0d_rsp0_rdata", i), rr_rd0, (prev_g == 0) ? 32'hDEADBEEF : 32'h0);
        chk($sformatf("cont%0d_rsp1_rdata", i), rr_rd1, (prev_g == 1) ? 32'h11BB33DD : 32'h0);
      end
      if (i < 10) begin
        chk($sformatf("fixed%0d_ready0", i), 32'(fp_ready0), 32'h1);
        chk($sformatf("fixed%0d_ready1", i), 32'(fp_ready1), 32'h0);
      end
      chk($sformatf("hold1_%0d_ready0", i), 32'(h1_ready0), 32'(i % 2 == 0));
      chk($sformatf("hold1_%0d_ready1", i), 32'(h1_ready1), 32'(i % 2 == 1));
      prev_g = exp_g;
    end

    // Port 0 drops: port 1 granted in that same cycle on every instance.
    @(posedge clk);
    #1;
    drive(NONE, rd(16'h0030));
    @(negedge clk);
    chk("drop0_fixed_ready1", 32'(fp_ready1), 32'h1);
    chk("drop0_fixed_ready0", 32'(fp_ready0), 32'h0);
    chk("drop0_rr_ready1",    32'(rr_ready1), 32'h1);
    chk("drop0_rr_rsp0_valid", 32'(rr_rv0),   32'h1);
    @(posedge clk);
    #1;
    drive(NONE, NONE);
    @(negedge clk);
    chk("drop0_rr_rsp1_rdata", rr_rd1, 32'h11BB33DD);
    chk("drop0_fixed_rsp1_valid", 32'(fp_rv1), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
